// File: rtl/panex_move_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : panex_move_feeder
//  Description : Upstream move feeder for the Panex puzzle core. Accepts
//                (fr,to) moves over a valid/ready handshake, drops illegal
//                moves, buffers legal ones in a small FIFO and issues at most
//                one move per cycle on registered fr/to outputs.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEPTH   FIFO entries (power of 2, >= 2)
//    CW      width of the issued-move and rejected-move counters
//  Ports
//    clk      in   clock, all state changes on posedge
//    rst      in   synchronous reset, active-low
//    in_vld   in   upstream move valid
//    in_fr    in   upstream source rod (00 left, 01 middle, 10 right)
//    in_to    in   upstream target rod
//    in_rdy   out  feeder can accept a move this cycle
//    hold     in   pause issuing; buffered moves are retained
//    out_vld  out  fr/to carry a real move this cycle
//    fr       out  source rod to core; 2'b11 when idle
//    to       out  target rod to core; 2'b11 when idle
//    mv_cnt   out  moves issued since reset (saturating)
//    rej_cnt  out  illegal moves dropped since reset (saturating)
//    rej_p    out  one-cycle pulse the cycle after a drop
// ============================================================================
module panex_move_feeder #(
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  input  logic [1:0]    in_fr,
  input  logic [1:0]    in_to,
  output logic          in_rdy,
  input  logic          hold,
  output logic          out_vld,
  output logic [1:0]    fr,
  output logic [1:0]    to,
  output logic [CW-1:0] mv_cnt,
  output logic [CW-1:0] rej_cnt,
  output logic          rej_p
);

  localparam int         AW     = $clog2(DEPTH);
  localparam logic [1:0] C_NOOP = 2'b11;

  // FIFO storage, each entry is {fr, to}
  logic [3:0]    mem_q [DEPTH];
  logic [3:0]    mem_d [DEPTH];

  // Pointers carry one extra wrap bit so full and empty can be told apart
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;

  logic          out_vld_q, out_vld_d;
  logic [1:0]    fr_q, fr_d;
  logic [1:0]    to_q, to_d;
  logic [CW-1:0] mv_cnt_q, mv_cnt_d;
  logic [CW-1:0] rej_cnt_q, rej_cnt_d;
  logic          rej_p_q, rej_p_d;

  logic          w_empty;
  logic          w_full;
  logic          w_xfer;
  logic          w_legal;
  logic          w_push;
  logic          w_drop;
  logic          w_pop;
  logic [3:0]    w_head;

  assign w_empty = (wr_ptr_q == rd_ptr_q);
  assign w_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Ready depends only on occupancy; it is also forced low while reset is
  // asserted so a move presented in the reset cycle is never consumed.
  assign in_rdy  = rst && !w_full;

  assign w_xfer  = in_vld && in_rdy;
  assign w_legal = (in_fr != in_to) && (in_fr != C_NOOP) && (in_to != C_NOOP);
  assign w_push  = w_xfer && w_legal;
  assign w_drop  = w_xfer && !w_legal;

  // Pop looks only at the registered pointers, so an entry written on this
  // edge cannot be issued on the same edge.
  assign w_pop   = !w_empty && !hold;
  assign w_head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    out_vld_d = 1'b0;
    fr_d      = C_NOOP;
    to_d      = C_NOOP;
    mv_cnt_d  = mv_cnt_q;
    rej_cnt_d = rej_cnt_q;
    rej_p_d   = w_drop;

    if (w_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = {in_fr, in_to};
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end

    if (w_pop) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      out_vld_d = 1'b1;
      fr_d      = w_head[3:2];
      to_d      = w_head[1:0];
      if (mv_cnt_q != {CW{1'b1}}) begin
        mv_cnt_d = mv_cnt_q + CW'(1);
      end
    end

    if (w_drop && (rej_cnt_q != {CW{1'b1}})) begin
      rej_cnt_d = rej_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 4'b0000;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      out_vld_q <= 1'b0;
      fr_q      <= C_NOOP;
      to_q      <= C_NOOP;
      mv_cnt_q  <= '0;
      rej_cnt_q <= '0;
      rej_p_q   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      out_vld_q <= out_vld_d;
      fr_q      <= fr_d;
      to_q      <= to_d;
      mv_cnt_q  <= mv_cnt_d;
      rej_cnt_q <= rej_cnt_d;
      rej_p_q   <= rej_p_d;
    end
  end

  assign out_vld = out_vld_q;
  assign fr      = fr_q;
  assign to      = to_q;
  assign mv_cnt  = mv_cnt_q;
  assign rej_cnt = rej_cnt_q;
  assign rej_p   = rej_p_q;

endmodule
`default_nettype wire

// File: tb/tb_panex_move_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_panex_move_feeder
//  Description : Self-checking bench for panex_move_feeder. A per-cycle
//                vector table covers reset, single issue, drops and the
//                hold/full sequence; hand-written sequences cover a random
//                gap stream with a scoreboard, mid-run reset and counter
//                saturation on a narrow-counter instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_panex_move_feeder;

  logic        clk;
  logic        rst;
  logic        in_vld;
  logic [1:0]  in_fr;
  logic [1:0]  in_to;
  logic        hold;

  logic        in_rdy;
  logic        out_vld;
  logic [1:0]  fr;
  logic [1:0]  to;
  logic [15:0] mv_cnt;
  logic [15:0] rej_cnt;
  logic        rej_p;

  logic        s_in_rdy;
  logic        s_out_vld;
  logic [1:0]  s_fr;
  logic [1:0]  s_to;
  logic [3:0]  s_mv_cnt;
  logic [3:0]  s_rej_cnt;
  logic        s_rej_p;

  int errors = 0;
  int checks = 0;

  panex_move_feeder #(.DEPTH(4), .CW(16)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_fr(in_fr), .in_to(in_to),
    .in_rdy(in_rdy), .hold(hold), .out_vld(out_vld), .fr(fr), .to(to),
    .mv_cnt(mv_cnt), .rej_cnt(rej_cnt), .rej_p(rej_p)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation
  panex_move_feeder #(.DEPTH(4), .CW(4)) dut_s (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_fr(in_fr), .in_to(in_to),
    .in_rdy(s_in_rdy), .hold(hold), .out_vld(s_out_vld), .fr(s_fr), .to(s_to),
    .mv_cnt(s_mv_cnt), .rej_cnt(s_rej_cnt), .rej_p(s_rej_p)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        vld;
    logic [1:0]  fr;
    logic [1:0]  to;
    logic        hold;
    logic        rdy;     // in_rdy during the cycle
    logic        ovld;    // outputs after the following posedge
    logic [1:0]  efr;
    logic [1:0]  eto;
    logic [15:0] mv;
    logic [15:0] rej;
    logic        rp;
  } vec_t;

  function automatic vec_t mk(logic r, logic v, logic [1:0] f, logic [1:0] t, logic h,
                              logic rdy, logic ov, logic [1:0] ef, logic [1:0] et,
                              logic [15:0] mv, logic [15:0] rej, logic rp);
    vec_t x;
    x.rst = r; x.vld = v; x.fr = f; x.to = t; x.hold = h;
    x.rdy = rdy; x.ovld = ov; x.efr = ef; x.eto = et;
    x.mv = mv; x.rej = rej; x.rp = rp;
    return x;
  endfunction

  localparam int NV = 19;
  vec_t vt [NV];

  // Called at posedge+1: drive, check ready, advance one edge, sample at +1
  task automatic drive(input logic r, input logic v, input logic [1:0] f,
                       input logic [1:0] t, input logic h);
    rst = r; in_vld = v; in_fr = f; in_to = t; hold = h;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    tick();
    drive(1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
  endtask

  logic [3:0] pairs [6];
  logic [3:0] q [$];
  logic [3:0] got;
  logic [3:0] head;
  logic       acc;
  int         sent;
  int         cyc;
  int         seen_vld;

  initial begin
    rst = 1'b0; in_vld = 1'b0; in_fr = 2'b00; in_to = 2'b00; hold = 1'b0;

    // ---- reset, single move, drops, hold/full sequence -----------------
    //            rst vld fr     to     hold rdy ovld efr    eto    mv  rej rp
    vt[0]  = mk(0, 0, 2'b00, 2'b00, 0,  0,  0, 2'b11, 2'b11, 0, 0, 0);
    vt[1]  = mk(1, 1, 2'b00, 2'b10, 0,  1,  0, 2'b11, 2'b11, 0, 0, 0);
    vt[2]  = mk(1, 0, 2'b00, 2'b00, 0,  1,  1, 2'b00, 2'b10, 1, 0, 0);
    vt[3]  = mk(1, 0, 2'b00, 2'b00, 0,  1,  0, 2'b11, 2'b11, 1, 0, 0);
    vt[4]  = mk(1, 1, 2'b01, 2'b01, 0,  1,  0, 2'b11, 2'b11, 1, 1, 1);
    vt[5]  = mk(1, 1, 2'b11, 2'b00, 0,  1,  0, 2'b11, 2'b11, 1, 2, 1);
    vt[6]  = mk(1, 1, 2'b00, 2'b11, 0,  1,  0, 2'b11, 2'b11, 1, 3, 1);
    vt[7]  = mk(1, 0, 2'b00, 2'b00, 0,  1,  0, 2'b11, 2'b11, 1, 3, 0);
    vt[8]  = mk(1, 1, 2'b00, 2'b01, 1,  1,  0, 2'b11, 2'b11, 1, 3, 0);
    vt[9]  = mk(1, 1, 2'b01, 2'b10, 1,  1,  0, 2'b11, 2'b11, 1, 3, 0);
    vt[10] = mk(1, 1, 2'b10, 2'b00, 1,  1,  0, 2'b11, 2'b11, 1, 3, 0);
    vt[11] = mk(1, 1, 2'b00, 2'b10, 1,  1,  0, 2'b11, 2'b11, 1, 3, 0);
    vt[12] = mk(1, 1, 2'b01, 2'b00, 1,  0,  0, 2'b11, 2'b11, 1, 3, 0);
    vt[13] = mk(1, 1, 2'b01, 2'b00, 0,  0,  1, 2'b00, 2'b01, 2, 3, 0);
    vt[14] = mk(1, 1, 2'b01, 2'b00, 0,  1,  1, 2'b01, 2'b10, 3, 3, 0);
    vt[15] = mk(1, 0, 2'b00, 2'b00, 0,  1,  1, 2'b10, 2'b00, 4, 3, 0);
    vt[16] = mk(1, 0, 2'b00, 2'b00, 0,  1,  1, 2'b00, 2'b10, 5, 3, 0);
    vt[17] = mk(1, 0, 2'b00, 2'b00, 0,  1,  1, 2'b01, 2'b00, 6, 3, 0);
    vt[18] = mk(1, 0, 2'b00, 2'b00, 0,  1,  0, 2'b11, 2'b11, 6, 3, 0);

    #1;
    for (int i = 0; i < NV; i++) begin
      drive(vt[i].rst, vt[i].vld, vt[i].fr, vt[i].to, vt[i].hold);
      #1;
      chk($sformatf("v%0d_in_rdy", i), 32'(in_rdy), 32'(vt[i].rdy));
      tick();
      chk($sformatf("v%0d_out_vld", i), 32'(out_vld), 32'(vt[i].ovld));
      chk($sformatf("v%0d_fr_to", i), 32'({fr, to}), 32'({vt[i].efr, vt[i].eto}));
      chk($sformatf("v%0d_mv_cnt", i), 32'(mv_cnt), 32'(vt[i].mv));
      chk($sformatf("v%0d_rej_cnt", i), 32'(rej_cnt), 32'(vt[i].rej));
      chk($sformatf("v%0d_rej_p", i), 32'(rej_p), 32'(vt[i].rp));
    end

    // ---- stream 12 legal moves with random gaps and hold ---------------
    pairs[0] = 4'b0001; pairs[1] = 4'b0010; pairs[2] = 4'b0100;
    pairs[3] = 4'b0110; pairs[4] = 4'b1000; pairs[5] = 4'b1001;
    do_reset();
    sent = 0;
    cyc  = 0;
    q.delete();
    while ((sent < 12 || q.size() > 0) && cyc < 400) begin
      got = pairs[sent % 6];
      drive(1'b1, (sent < 12) && ($urandom_range(0, 3) != 0), got[3:2], got[1:0],
            $urandom_range(0, 3) == 0);
      #1;
      acc = in_vld && in_rdy;
      tick();
      if (out_vld) begin
        if (q.size() == 0) begin
          chk("stream_unexpected_issue", 32'({fr, to}), 32'hFF);
        end else begin
          head = q.pop_front();
          chk("stream_order", 32'({fr, to}), 32'(head));
        end
      end
      if (acc) begin
        q.push_back(got);
        sent++;
      end
      cyc++;
    end
    chk("stream_completed", 32'(sent == 12 && q.size() == 0), 32'd1);
    chk("stream_mv_cnt", 32'(mv_cnt), 32'd12);

    // ---- reset with three buffered moves -------------------------------
    drive(1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      got = pairs[i];
      drive(1'b1, 1'b1, got[3:2], got[1:0], 1'b1);
      tick();
    end
    drive(1'b0, 1'b1, 2'b10, 2'b01, 1'b0);
    #1;
    chk("rst_in_rdy_low", 32'(in_rdy), 32'd0);
    tick();
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_fr_to", 32'({fr, to}), 32'hF);
    chk("rst_mv_cnt", 32'(mv_cnt), 32'd0);
    chk("rst_rej_cnt", 32'(rej_cnt), 32'd0);
    chk("rst_rej_p", 32'(rej_p), 32'd0);
    drive(1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
    #1;
    chk("rst_release_in_rdy", 32'(in_rdy), 32'd1);
    seen_vld = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_vld) seen_vld++;
    end
    chk("rst_old_moves_lost", 32'(seen_vld), 32'd0);

    // ---- counter saturation: 17 moves back to back ---------------------
    for (int i = 0; i < 17; i++) begin
      got = pairs[i % 6];
      drive(1'b1, 1'b1, got[3:2], got[1:0], 1'b0);
      tick();
    end
    drive(1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    chk("sat_narrow_mv_cnt", 32'(s_mv_cnt), 32'hF);
    chk("sat_wide_mv_cnt", 32'(mv_cnt), 32'd17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
